// File: rtl/fetch_queue_unit_if.sv
// Fetch-stage bus bundle: imem request/response, branch redirect and decode-side queue head.
// master = fetch unit, slave = environment (memory, branch unit, decode).
interface fetch_queue_unit_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4
);
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [PC_W-1:0]        imem_req_addr;
  logic                   imem_rsp_valid;
  logic [INS_W-1:0]       imem_rsp_data;
  logic                   redirect;
  logic [PC_W-1:0]        redirect_pc;
  logic                   id_valid;
  logic                   id_ready;
  logic [PC_W-1:0]        id_pc;
  logic [INS_W-1:0]       id_instr;
  logic [$clog2(DEPTH):0] q_count;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, q_count,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, q_count,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch: PC owner, credit-limited imem requests, DEPTH-entry queue; rsp->decode 1 cycle,
// decode stall stops fetch once credits run out. FETCH_BYPASS_EN adds a 0-cycle empty-queue bypass.
module fetch_queue_unit #(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               reset,
  fetch_queue_unit_if.master bus
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int QAW = $clog2(DEPTH);
  localparam int FAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]  MAXO_C  = CW'(MAX_OUT);
  localparam logic [FAW-1:0] FLAST   = FAW'(MAX_OUT - 1);

  logic [PC_W-1:0]  fetch_pc;
  logic             started;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    discard;
  logic [PC_W-1:0]  infl_pc [MAX_OUT];
  logic [FAW-1:0]   infl_rd, infl_wr;
  logic [PC_W-1:0]  q_pc  [DEPTH];
  logic [INS_W-1:0] q_ins [DEPTH];
  logic [QAW-1:0]   q_rd, q_wr;
  logic [CW-1:0]    q_count;

  logic rsp_ok, live_rsp, credit_ok, req_valid, fire;
  logic q_head_vld, byp_vld, push, pop;
  logic [PC_W-1:0] rsp_pc, redirect_aligned;

  // A response arriving with nothing in flight is a protocol error and is ignored.
  assign rsp_ok    = bus.imem_rsp_valid & (outstanding != '0);
  assign live_rsp  = rsp_ok & (discard == '0) & ~bus.redirect;
  assign rsp_pc    = infl_pc[infl_rd];
  assign credit_ok = (({1'b0, q_count} + {1'b0, outstanding}) < DEPTH_C);
  assign req_valid = started & ~bus.redirect & (outstanding < MAXO_C) & credit_ok;
  assign fire      = req_valid & bus.imem_req_ready;
  assign redirect_aligned = bus.redirect_pc & ~PC_W'(3);

  assign q_head_vld = (q_count != '0);
`ifdef FETCH_BYPASS_EN
  assign byp_vld = live_rsp & ~q_head_vld;
`else
  assign byp_vld = 1'b0;
`endif
  assign pop  = q_head_vld & bus.id_ready & ~bus.redirect;
  assign push = live_rsp & ~(byp_vld & bus.id_ready);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.q_count        = q_count;

  always_comb begin
    bus.id_valid = q_head_vld | byp_vld;
    bus.id_pc    = '0;
    bus.id_instr = '0;
    if (q_head_vld) begin
      bus.id_pc    = q_pc[q_rd];
      bus.id_instr = q_ins[q_rd];
    end else if (byp_vld) begin
      bus.id_pc    = rsp_pc;
      bus.id_instr = bus.imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      started     <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
      infl_rd     <= '0;
      infl_wr     <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      q_count     <= '0;
    end else begin
      started <= 1'b1;
      if (bus.redirect)
        fetch_pc <= redirect_aligned;
      else if (fire)
        fetch_pc <= fetch_pc + PC_W'(4);

      outstanding <= outstanding + CW'(fire) - CW'(rsp_ok);
      if (fire)
        infl_wr <= (infl_wr == FLAST) ? '0 : infl_wr + FAW'(1);
      // Stale responses still retire their in-flight PC so the FIFO stays aligned.
      if (rsp_ok)
        infl_rd <= (infl_rd == FLAST) ? '0 : infl_rd + FAW'(1);

      if (bus.redirect)
        discard <= outstanding - CW'(rsp_ok);
      else if (rsp_ok && discard != '0)
        discard <= discard - CW'(1);

      if (bus.redirect) begin
        q_rd    <= '0;
        q_wr    <= '0;
        q_count <= '0;
      end else begin
        if (push)
          q_wr <= q_wr + QAW'(1);
        if (pop)
          q_rd <= q_rd + QAW'(1);
        q_count <= q_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire)
      infl_pc[infl_wr] <= fetch_pc;
    if (push) begin
      q_pc[q_wr]  <= rsp_pc;
      q_ins[q_wr] <= bus.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a variable-latency in-order memory model.
module tb_fetch_queue_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  fetch_queue_unit_if #(.PC_W(9), .INS_W(32), .DEPTH(4)) bus ();

  fetch_queue_unit #(.PC_W(9), .INS_W(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(9'h000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] addr; int due; } pend_t;
  pend_t      pend[$];
  logic [8:0] issued[$];
  logic [8:0] got_pc[$];
  logic [31:0] got_ins[$];
  int lat      = 1;
  int rdy_mode = 0;
  int stray_req = 0;
  int stray_seen = 0;
  int mdl_out  = 0;
  int cyc      = 0;

  function automatic logic [31:0] instr_of(input logic [8:0] a);
    return 32'hC000_0000 | {23'b0, a};
  endfunction

  // Memory model and consumption monitor: samples at the edge, drives 1 time unit later.
  initial begin
    logic s_fire, s_rsp, s_cons;
    logic [8:0] s_addr, s_pc;
    logic [31:0] s_ins;
    logic rsp_real;
    rsp_real = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      s_fire = bus.imem_req_valid && bus.imem_req_ready;
      s_addr = bus.imem_req_addr;
      s_rsp  = bus.imem_rsp_valid && rsp_real;
      s_cons = bus.id_valid && bus.id_ready && !bus.redirect;
      s_pc   = bus.id_pc;
      s_ins  = bus.id_instr;
      #1;
      cyc++;
      if (!reset) begin
        pend.delete();
        mdl_out = 0;
        rsp_real = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end else begin
        if (s_fire) begin
          pend.push_back('{s_addr, cyc - 1 + lat});
          issued.push_back(s_addr);
          mdl_out++;
        end
        if (s_rsp) mdl_out--;
        if (s_cons) begin
          got_pc.push_back(s_pc);
          got_ins.push_back(s_ins);
        end
        if (stray_req != stray_seen) begin
          stray_seen = stray_req;
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = 32'hDEAD_BEEF;
          rsp_real = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = instr_of(pend[0].addr);
          rsp_real = 1'b1;
          void'(pend.pop_front());
        end else begin
          bus.imem_rsp_valid = 1'b0;
          bus.imem_rsp_data  = '0;
          rsp_real = 1'b0;
        end
      end
      bus.imem_req_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", bus.imem_req_valid); end
    total++; if (bus.imem_req_addr !== 9'h000) begin bad++; $display("FAIL rst_req_addr got=%h exp=000", bus.imem_req_addr); end
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid got=%b exp=0", bus.id_valid); end
    total++; if (bus.id_pc !== 9'h000) begin bad++; $display("FAIL rst_id_pc got=%h exp=000", bus.id_pc); end
    total++; if (bus.id_instr !== 32'h0) begin bad++; $display("FAIL rst_id_instr got=%h exp=0", bus.id_instr); end
    total++; if (bus.q_count !== 3'd0) begin bad++; $display("FAIL rst_q_count got=%0d exp=0", bus.q_count); end
    tick();
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL release_cycle_valid got=%b exp=0", bus.imem_req_valid); end
    tick();
    @(negedge clk);
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 9'h000) begin
      bad++; $display("FAIL first_req got=%b/%h exp=1/000", bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  task automatic test_stream();
    int n = 0;
    while (bus.id_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++; if (n >= 10) begin bad++; $display("FAIL stream_timeout got=no id_valid exp=id_valid"); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 9'(4*i) || bus.id_instr !== instr_of(9'(4*i)) || bus.q_count !== 3'd1) begin
        bad++; $display("FAIL stream_%0d got=v%b pc=%h ins=%h q=%0d exp=v1 pc=%h q=1",
                        i, bus.id_valid, bus.id_pc, bus.id_instr, bus.q_count, 9'(4*i));
      end
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      total++; if (issued[i] !== 9'(4*i)) begin bad++; $display("FAIL stream_addr_%0d got=%h exp=%h", i, issued[i], 9'(4*i)); end
    end
  endtask

  task automatic test_stall();
    int b;
    bus.id_ready = 1'b0;
    do_reset();
    b = issued.size();
    repeat (10) tick();
    @(negedge clk);
    total++; if (issued.size() - b != 4) begin bad++; $display("FAIL stall_fires got=%0d exp=4", issued.size() - b); end
    total++; if (bus.q_count !== 3'd4) begin bad++; $display("FAIL stall_q_count got=%0d exp=4", bus.q_count); end
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid got=%b exp=0", bus.imem_req_valid); end
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 9'h000 || bus.id_instr !== instr_of(9'h000)) begin
      bad++; $display("FAIL stall_head got=v%b pc=%h ins=%h exp=v1 pc=000", bus.id_valid, bus.id_pc, bus.id_instr);
    end
    tick();
    bus.id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 9'(4*i)) begin
        bad++; $display("FAIL drain_%0d got=v%b pc=%h exp=v1 pc=%h", i, bus.id_valid, bus.id_pc, 9'(4*i));
      end
    end
  endtask

  task automatic test_redirect();
    int n = 0;
    int gb, ib;
    bus.id_ready = 1'b1;
    lat = 2;
    do_reset();
    while (!(mdl_out == 2 && bus.imem_rsp_valid === 1'b1) && n < 40) begin tick(); n++; end
    total++; if (n >= 40) begin bad++; $display("FAIL redir_setup got=out%0d exp=out2+rsp", mdl_out); end
    bus.redirect = 1'b1;
    bus.redirect_pc = 9'h041;
    @(negedge clk);
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_cycle_valid got=%b exp=0", bus.imem_req_valid); end
    tick();
    bus.redirect = 1'b0;
    gb = got_pc.size();
    ib = issued.size();
    @(negedge clk);
    total++; if (bus.q_count !== 3'd0 || bus.id_valid !== 1'b0) begin
      bad++; $display("FAIL redir_flush got=q%0d v%b exp=q0 v0", bus.q_count, bus.id_valid);
    end
    total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 9'h040) begin
      bad++; $display("FAIL redir_req got=%b/%h exp=1/040", bus.imem_req_valid, bus.imem_req_addr);
    end
    n = 0;
    while (got_pc.size() < gb + 2 && n < 30) begin tick(); n++; end
    total++; if (n >= 30) begin bad++; $display("FAIL redir_timeout got=%0d exp=2 consumed", got_pc.size() - gb); end
    else begin
      total++; if (got_pc[gb] !== 9'h040 || got_ins[gb] !== instr_of(9'h040)) begin
        bad++; $display("FAIL redir_first got=%h/%h exp=040/%h", got_pc[gb], got_ins[gb], instr_of(9'h040));
      end
      total++; if (got_pc[gb+1] !== 9'h044) begin bad++; $display("FAIL redir_second got=%h exp=044", got_pc[gb+1]); end
      total++; if (issued[ib] !== 9'h040) begin bad++; $display("FAIL redir_issue got=%h exp=040", issued[ib]); end
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    int gb, ib;
    lat = 1;
    repeat (3) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 9'h1FC;
    tick();
    bus.redirect = 1'b0;
    gb = got_pc.size();
    ib = issued.size();
    while ((got_pc.size() < gb + 2 || issued.size() < ib + 2) && n < 30) begin tick(); n++; end
    total++; if (n >= 30) begin bad++; $display("FAIL wrap_timeout got=%0d exp=2 consumed", got_pc.size() - gb); end
    else begin
      total++; if (issued[ib] !== 9'h1FC || issued[ib+1] !== 9'h000) begin
        bad++; $display("FAIL wrap_addr got=%h,%h exp=1fc,000", issued[ib], issued[ib+1]);
      end
      total++; if (got_pc[gb] !== 9'h1FC || got_pc[gb+1] !== 9'h000) begin
        bad++; $display("FAIL wrap_id got=%h,%h exp=1fc,000", got_pc[gb], got_pc[gb+1]);
      end
    end
  endtask

  task automatic test_toggle();
    int k = 0;
    int gb;
    lat = 3;
    rdy_mode = 1;
    do_reset();
    gb = got_pc.size();
    while (got_pc.size() < gb + 50 && k < 2000) begin
      tick();
      bus.id_ready = (k % 4 != 3);
      k++;
      @(negedge clk);
      total++; if (mdl_out > 2 || bus.q_count > 3'd4) begin
        bad++; $display("FAIL toggle_limits got=out%0d q%0d exp=out<=2 q<=4", mdl_out, bus.q_count);
      end
    end
    rdy_mode = 0;
    bus.id_ready = 1'b1;
    total++; if (k >= 2000) begin bad++; $display("FAIL toggle_timeout got=%0d exp=50", got_pc.size() - gb); end
    else begin
      for (int i = 0; i < 50; i++) begin
        total++; if (got_pc[gb+i] !== 9'(4*i) || got_ins[gb+i] !== instr_of(9'(4*i))) begin
          bad++; $display("FAIL toggle_seq_%0d got=%h/%h exp=%h", i, got_pc[gb+i], got_ins[gb+i], 9'(4*i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int ib;
    lat = 1;
    bus.id_ready = 1'b0;
    do_reset();
    while (!(bus.q_count === 3'd3 && mdl_out == 1) && n < 20) begin tick(); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL midrst_setup got=q%0d out%0d exp=q3 out1", bus.q_count, mdl_out); end
    reset = 1'b0;
    #1;
    total++; if (bus.id_valid !== 1'b0 || bus.q_count !== 3'd0 || bus.imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_clear got=v%b q%0d rv%b exp=v0 q0 rv0", bus.id_valid, bus.q_count, bus.imem_req_valid);
    end
    tick();
    tick();
    reset = 1'b1;
    stray_req++;
    ib = issued.size();
    tick();
    tick();
    @(negedge clk);
    total++; if (bus.q_count !== 3'd0 || bus.id_valid !== 1'b0) begin
      bad++; $display("FAIL stray_ignored got=q%0d v%b exp=q0 v0", bus.q_count, bus.id_valid);
    end
    tick();
    @(negedge clk);
    total++; if (bus.q_count !== 3'd1 || bus.id_pc !== 9'h000 || bus.id_instr !== instr_of(9'h000)) begin
      bad++; $display("FAIL restart_head got=q%0d pc=%h ins=%h exp=q1 pc=000 ins=%h",
                      bus.q_count, bus.id_pc, bus.id_instr, instr_of(9'h000));
    end
    total++; if (issued.size() <= ib || issued[ib] !== 9'h000) begin
      bad++; $display("FAIL restart_addr got=n%0d exp=first fetch 000", issued.size() - ib);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_toggle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
